// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift/add (multiply) or restoring
// subtract (divide) step per cycle, with a stall request while it is working.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall_req
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN-1);

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;
  state_t state, state_nx;

  logic [2:0]      f_q;
  logic [XLEN-1:0] a_q, b_q, d_q, hi_q, lo_q, result_q;
  logic            neg_q, busy_q, done_q;
  logic [CW-1:0]   count_q;

  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_val;

  logic [XLEN:0]   mul_sum, div_shift;
  logic [XLEN-1:0] mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
  logic            div_ok;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] mul_res, div_res, calc_res;

  logic            load_result;
  logic [XLEN-1:0] result_nx;

  // Operand signedness: MULHSU has a signed rs1 and unsigned rs2
  assign is_div   = f_q[2];
  assign a_signed = is_div ? ~f_q[0] : (f_q[1:0] != 2'b11);
  assign b_signed = is_div ? ~f_q[0] : ~f_q[1];
  assign a_neg    = a_signed & a_q[XLEN-1];
  assign b_neg    = b_signed & b_q[XLEN-1];
  assign a_abs    = a_neg ? -a_q : a_q;
  assign b_abs    = b_neg ? -b_q : b_q;

  assign div_zero    = is_div & (b_q == '0);
  assign div_ovf     = is_div & ~f_q[0] & (a_q == MIN_NEG) & (&b_q);
  assign special_val = div_zero ? (f_q[1] ? a_q : '1) : (f_q[1] ? '0 : MIN_NEG);

  // hi/lo hold {product upper, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
  assign mul_hi_nx = mul_sum[XLEN:1];
  assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ok    = (div_shift >= {1'b0, d_q});
  assign div_hi_nx = div_ok ? (div_shift[XLEN-1:0] - d_q) : div_shift[XLEN-1:0];
  assign div_lo_nx = {lo_q[XLEN-2:0], div_ok};

  assign prod     = {mul_hi_nx, mul_lo_nx};
  assign prod_fix = neg_q ? -prod : prod;
  assign mul_res  = (f_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign div_res  = f_q[1] ? (neg_q ? -div_hi_nx : div_hi_nx)
                           : (neg_q ? -div_lo_nx : div_lo_nx);
  assign calc_res = is_div ? div_res : mul_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    load_result = 1'b0;
    result_nx   = result_q;
    case (state)
      IDLE: if (start && !flush) state_nx = PREP;
      PREP: begin
        if (flush) state_nx = IDLE;
        else if (div_zero || div_ovf) begin
          state_nx    = DONE;
          load_result = 1'b1;
          result_nx   = special_val;
        end else state_nx = CALC;
      end
      CALC: begin
        if (flush) state_nx = IDLE;
        else if (count_q == LAST) begin
          state_nx    = DONE;
          load_result = 1'b1;
          result_nx   = calc_res;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            f_q <= funct3;
            a_q <= op_a;
            b_q <= op_b;
          end
        end
        PREP: begin
          count_q <= '0;
          hi_q    <= '0;
          neg_q   <= a_neg ^ (b_neg & ~(is_div & f_q[1]));
          lo_q    <= is_div ? a_abs : b_abs;
          d_q     <= is_div ? b_abs : a_abs;
        end
        CALC: begin
          count_q <= count_q + 1'b1;
          hi_q    <= is_div ? div_hi_nx : mul_hi_nx;
          lo_q    <= is_div ? div_lo_nx : mul_lo_nx;
        end
        default: ;
      endcase
      if (load_result) result_q <= result_nx;
      busy_q <= (state_nx == PREP) || (state_nx == CALC);
      done_q <= (state_nx == DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign stall_req = busy_q | (start & (state == IDLE) & ~flush);

endmodule
